// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS-subset control FSM with a retired-instruction counter.
// Define CTRL_TRAP_EN to trap on illegal opcodes instead of treating them as NOPs.
module multi_cycle_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  opIn,
    input  logic [5:0]  funcIn,
    input  logic        zeroIn,
    input  logic        memReadyIn,
    output logic        pcWrite,
    output logic        pcWriteCond,
    output logic        irWrite,
    output logic        memRead,
    output logic        memWrite,
    output logic        regWrite,
    output logic        regDst,
    output logic        memToReg,
    output logic        aluSrcA,
    output logic        trap,
    output logic [1:0]  aluSrcB,
    output logic [1:0]  pcSource,
    output logic [2:0]  aluOp,
    output logic [2:0]  state,
    output logic [15:0] retired
);

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StTrap   = 3'd5
    } stateT;

    localparam logic [5:0] OpRType = 6'h00;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpAddi  = 6'h08;

    localparam logic [5:0] FnAdd = 6'h20;
    localparam logic [5:0] FnSub = 6'h22;
    localparam logic [5:0] FnAnd = 6'h24;
    localparam logic [5:0] FnOr  = 6'h25;
    localparam logic [5:0] FnSlt = 6'h2A;

    localparam logic [2:0] AluAdd = 3'd0;
    localparam logic [2:0] AluSub = 3'd1;
    localparam logic [2:0] AluAnd = 3'd2;
    localparam logic [2:0] AluOr  = 3'd3;
    localparam logic [2:0] AluSlt = 3'd4;

    stateT       stateQ, stateD;
    logic [15:0] retiredQ;
    logic        retire;

    logic       funcOk;
    logic [2:0] funcAluOp;
    logic       isRType, isLw, isSw, isBeq, isJ, isAddi, isLegal;

    // The zero flag is ANDed with pcWriteCond in the datapath, not here.
    logic unusedZero;
    assign unusedZero = zeroIn;

    always_comb begin
        funcOk    = 1'b1;
        funcAluOp = AluAdd;
        case (funcIn)
            FnAdd:   funcAluOp = AluAdd;
            FnSub:   funcAluOp = AluSub;
            FnAnd:   funcAluOp = AluAnd;
            FnOr:    funcAluOp = AluOr;
            FnSlt:   funcAluOp = AluSlt;
            default: funcOk    = 1'b0;
        endcase
    end

    assign isRType = (opIn == OpRType) && funcOk;
    assign isLw    = (opIn == OpLw);
    assign isSw    = (opIn == OpSw);
    assign isBeq   = (opIn == OpBeq);
    assign isJ     = (opIn == OpJ);
    assign isAddi  = (opIn == OpAddi);
    assign isLegal = isRType | isLw | isSw | isBeq | isJ | isAddi;

    always_comb begin
        stateD      = stateQ;
        retire      = 1'b0;
        pcWrite     = 1'b0;
        pcWriteCond = 1'b0;
        irWrite     = 1'b0;
        memRead     = 1'b0;
        memWrite    = 1'b0;
        regWrite    = 1'b0;
        regDst      = 1'b0;
        memToReg    = 1'b0;
        aluSrcA     = 1'b0;
        trap        = 1'b0;
        aluSrcB     = 2'd0;
        pcSource    = 2'd0;
        aluOp       = AluAdd;

        case (stateQ)
            StFetch: begin
                memRead = 1'b1;
                aluSrcB = 2'd1;
                // IR and PC only capture once the instruction word is actually back.
                if (memReadyIn) begin
                    irWrite = 1'b1;
                    pcWrite = 1'b1;
                    stateD  = StDecode;
                end
            end

            StDecode: begin
                aluSrcB = 2'd3;
                if (isLegal) begin
                    stateD = StExec;
                end else begin
`ifdef CTRL_TRAP_EN
                    stateD = StTrap;
`else
                    stateD = StFetch;
`endif
                end
            end

            StExec: begin
                stateD = StFetch;
                if (isRType) begin
                    aluSrcA = 1'b1;
                    aluOp   = funcAluOp;
                    stateD  = StWb;
                end else if (isLw || isSw || isAddi) begin
                    aluSrcA = 1'b1;
                    aluSrcB = 2'd2;
                    stateD  = isAddi ? StWb : StMem;
                end else if (isBeq) begin
                    aluSrcA     = 1'b1;
                    aluOp       = AluSub;
                    pcWriteCond = 1'b1;
                    pcSource    = 2'd1;
                    retire      = 1'b1;
                end else if (isJ) begin
                    pcWrite  = 1'b1;
                    pcSource = 2'd2;
                    retire   = 1'b1;
                end
            end

            StMem: begin
                if (isLw) begin
                    memRead = 1'b1;
                    if (memReadyIn) stateD = StWb;
                end else if (isSw) begin
                    memWrite = 1'b1;
                    if (memReadyIn) begin
                        stateD = StFetch;
                        retire = 1'b1;
                    end
                end else begin
                    stateD = StFetch;
                end
            end

            StWb: begin
                regWrite = 1'b1;
                regDst   = isRType;
                memToReg = isLw;
                retire   = 1'b1;
                stateD   = StFetch;
            end

`ifdef CTRL_TRAP_EN
            StTrap: begin
                trap   = 1'b1;
                stateD = StTrap;
            end
`endif

            default: stateD = StFetch;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ   <= StFetch;
            retiredQ <= 16'd0;
        end else begin
            stateQ <= stateD;
            if (retire) retiredQ <= retiredQ + 16'd1;
        end
    end

    assign state   = stateQ;
    assign retired = retiredQ;

    assert property (@(posedge clk) disable iff (rst) !(memRead && memWrite));
    assert property (@(posedge clk) disable iff (rst) !(regWrite && (memRead || memWrite)));
`ifndef CTRL_TRAP_EN
    assert property (@(posedge clk) disable iff (rst) stateQ != StTrap);
`endif

endmodule
